uart_program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 19 +
 rtl/uart_rx.sv | 88 ++++++++
 rtl/uart_program_loader.sv | 136 +++++++++++++
 tb/tb_uart_program_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      LOAD_LEN,
      LOAD_DATA,
      DONE
   } load_state_t;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver working on an already-synchronised line.
// Emits a one-cycle rx_valid with the byte on a good stop bit, or a
// one-cycle frame_err when the stop bit is sampled low.
module uart_rx
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_sync,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       bit_reg;
   logic [7:0]       shift_reg;

   // Receiver FSM: detect start, confirm it mid-bit, then sample each
   // following bit one bit period apart; outputs are registered pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= RX_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state_reg)
            RX_IDLE: begin
               cnt_reg <= '0;
               bit_reg <= '0;
               if (!rx_sync) begin
                  state_reg <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_reg == HALF_LAST) begin
                  cnt_reg <= '0;
                  // A line that is already high again was a glitch.
                  state_reg <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_reg   <= '0;
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  bit_reg   <= bit_reg + 1'b1;
                  if (bit_reg == 3'd7) begin
                     state_reg <= RX_STOP;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= RX_IDLE;
                  if (rx_sync) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= shift_reg;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image received over UART into program memory.
// Image format: 32-bit little-endian word count, then that many
// little-endian words. The core is held in reset until the image is in.
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          MAX_WORDS    = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_rx,
   output logic        mem_write_enable,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        framing_error,
   output logic        length_error
);

   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  sync_reg;
   logic        rx_sync;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        frame_err;

   load_state_t state_reg;
   logic [1:0]  lane_reg;
   logic [31:0] word_reg;
   logic [31:0] word_count_reg;
   logic [31:0] word_idx_reg;
   logic [31:0] assembled;

   // Two-flop synchroniser; idle-high so reset does not fake a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], io_rx};
      end
   end

   assign rx_sync = sync_reg[1];

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_rx (
      .clk      (clk),
      .reset    (reset),
      .rx_sync  (rx_sync),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .frame_err(frame_err)
   );

   // Newest byte lands in the top lane, so after four bytes the first
   // received byte sits in bits [7:0].
   assign assembled = {rx_byte, word_reg[31:8]};

   // Loader FSM with byte-lane counter, word assembly, address counter
   // and all status outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= LOAD_LEN;
         lane_reg         <= '0;
         word_reg         <= '0;
         word_count_reg   <= '0;
         word_idx_reg     <= '0;
         mem_write_enable <= 1'b0;
         mem_address      <= BASE_ADDR;
         mem_write_data   <= '0;
         cpu_hold         <= 1'b1;
         load_done        <= 1'b0;
         framing_error    <= 1'b0;
         length_error     <= 1'b0;
      end else begin
         mem_write_enable <= 1'b0;
         if (frame_err) begin
            framing_error <= 1'b1;
         end
         case (state_reg)
            LOAD_LEN: begin
               if (rx_valid) begin
                  lane_reg <= lane_reg + 1'b1;
                  word_reg <= assembled;
                  if (lane_reg == LAST_LANE) begin
                     word_count_reg <= assembled;
                     if (assembled == 32'd0) begin
                        state_reg <= DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                     end else if (assembled > 32'(MAX_WORDS)) begin
                        state_reg    <= DONE;
                        load_done    <= 1'b1;
                        cpu_hold     <= 1'b0;
                        length_error <= 1'b1;
                     end else begin
                        state_reg <= LOAD_DATA;
                     end
                  end
               end
            end
            LOAD_DATA: begin
               if (rx_valid) begin
                  lane_reg <= lane_reg + 1'b1;
                  word_reg <= assembled;
                  if (lane_reg == LAST_LANE) begin
                     mem_write_enable <= 1'b1;
                     mem_write_data   <= assembled;
                  end
               end
               // Address advances the cycle after each strobe; completion
               // is flagged on that same cycle after the final word.
               if (mem_write_enable) begin
                  mem_address  <= mem_address + 32'd4;
                  word_idx_reg <= word_idx_reg + 32'd1;
                  if (word_idx_reg == word_count_reg - 32'd1) begin
                     state_reg <= DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_reg <= DONE;
            end
            default: state_reg <= LOAD_LEN;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader at CLKS_PER_BIT=4.
module tb_uart_program_loader;

   localparam int CPB = 4;

   logic        clk;
   logic        reset;
   logic        io_rx;
   logic        mem_write_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        cpu_hold;
   logic        load_done;
   logic        framing_error;
   logic        length_error;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb_q[$];
   int  checks = 0;
   int  errors = 0;
   int  strobe_total = 0;
   logic done_pending = 1'b0;

   uart_program_loader #(
      .CLKS_PER_BIT(CPB),
      .BASE_ADDR   (32'h0000_0000),
      .MAX_WORDS   (256)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .io_rx           (io_rx),
      .mem_write_enable(mem_write_enable),
      .mem_address     (mem_address),
      .mem_write_data  (mem_write_data),
      .cpu_hold        (cpu_hold),
      .load_done       (load_done),
      .framing_error   (framing_error),
      .length_error    (length_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   // Strobe monitor: pops the scoreboard on each write, and checks that
   // completion appears exactly one cycle after the final strobe.
   always @(negedge clk) begin
      if (!reset) begin
         if (done_pending) begin
            check_eq("done_after_last", {30'd0, load_done, cpu_hold}, 32'h2);
            done_pending = 1'b0;
         end
         if (mem_write_enable) begin
            strobe_total++;
            check_eq("hold_at_strobe", {31'd0, cpu_hold}, 32'd1);
            if (sb_q.size() == 0) begin
               check_eq("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               wr_t w;
               w = sb_q.pop_front();
               check_eq("wr_addr", mem_address, w.addr);
               check_eq("wr_data", mem_write_data, w.data);
               if (sb_q.size() == 0) done_pending = 1'b1;
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 frame; a bad stop is held low only long enough to be
   // sampled, so the line is idle again before the receiver rearms.
   task automatic send_byte(input logic [7:0] b, input logic bad_stop = 1'b0);
      io_rx = 1'b0;
      wait_clk(CPB);
      for (int i = 0; i < 8; i++) begin
         io_rx = b[i];
         wait_clk(CPB);
      end
      if (bad_stop) begin
         io_rx = 1'b0;
         wait_clk(CPB - 1);
         io_rx = 1'b1;
         wait_clk(1);
      end else begin
         io_rx = 1'b1;
         wait_clk(CPB);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic expect_word(input logic [31:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      sb_q.push_back(w);
   endtask

   task automatic do_reset();
      io_rx = 1'b1;
      reset = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      done_pending = 1'b0;
      sb_q.delete();
      wait_clk(2);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_we"}, {31'd0, mem_write_enable}, 32'd0);
      check_eq({tag, "_addr"}, mem_address, 32'd0);
      check_eq({tag, "_data"}, mem_write_data, 32'd0);
      check_eq({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
      check_eq({tag, "_flags"}, {29'd0, load_done, framing_error, length_error}, 32'd0);
   endtask

   // Status after an image: {load_done, cpu_hold, framing, length}.
   task automatic check_status(input string tag, input logic [3:0] exp);
      check_eq(tag, {28'd0, load_done, cpu_hold, framing_error, length_error}, {28'd0, exp});
   endtask

   int base;

   initial begin
      io_rx = 1'b1;
      reset = 1'b1;
      wait_clk(4);
      check_reset_values("por");
      do_reset();

      // Two-word image.
      base = strobe_total;
      send_word(32'd2);
      check_status("two_hdr_busy", 4'b0100);
      expect_word(32'h0, 32'h00A0_0513);
      expect_word(32'h4, 32'h00B0_0593);
      send_word(32'h00A0_0513);
      send_word(32'h00B0_0593);
      wait_clk(8);
      check_status("two_done", 4'b1000);
      check_eq("two_strobes", 32'(strobe_total - base), 32'd2);

      // Zero-length image; a later byte must be ignored.
      do_reset();
      base = strobe_total;
      send_word(32'd0);
      wait_clk(4);
      check_status("zero_done", 4'b1000);
      send_byte(8'hFF);
      wait_clk(8);
      check_eq("zero_strobes", 32'(strobe_total - base), 32'd0);

      // Header over capacity.
      do_reset();
      base = strobe_total;
      send_word(32'd257);
      send_word(32'h1234_5678);
      wait_clk(8);
      check_status("len_err", 4'b1001);
      check_eq("len_strobes", 32'(strobe_total - base), 32'd0);

      // Single-cycle glitch before a valid one-word image.
      do_reset();
      base = strobe_total;
      io_rx = 1'b0;
      wait_clk(1);
      io_rx = 1'b1;
      wait_clk(3 * CPB);
      check_status("glitch_idle", 4'b0100);
      send_word(32'd1);
      expect_word(32'h0, 32'hDEAD_BEEF);
      send_word(32'hDEAD_BEEF);
      wait_clk(8);
      check_status("glitch_done", 4'b1000);
      check_eq("glitch_strobes", 32'(strobe_total - base), 32'd1);

      // Bad stop on second header byte, then resend it.
      do_reset();
      base = strobe_total;
      send_byte(8'h01);
      send_byte(8'h00, 1'b1);
      wait_clk(4);
      check_status("frame_err", 4'b0110);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      expect_word(32'h0, 32'h4433_2211);
      send_word(32'h4433_2211);
      wait_clk(8);
      check_status("frame_done", 4'b1010);
      check_eq("frame_strobes", 32'(strobe_total - base), 32'd1);

      // Reset during the third data byte, then a full reload.
      do_reset();
      send_word(32'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      io_rx = 1'b0;
      wait_clk(2 * CPB);
      reset = 1'b1;
      io_rx = 1'b1;
      wait_clk(3);
      check_reset_values("mid_rst");
      reset = 1'b0;
      wait_clk(2);
      base = strobe_total;
      send_word(32'd1);
      expect_word(32'h0, 32'hABCD_EF01);
      send_word(32'hABCD_EF01);
      wait_clk(8);
      check_status("reload_done", 4'b1000);
      check_eq("reload_strobes", 32'(strobe_total - base), 32'd1);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
